mem_access_stage: RTL and testbench
===================================

# mem_access_stage

MEM-stage consumer of the EX/MEM pipeline register outputs: performs the data-memory access for loads and stores over a variable-latency request/grant/read-valid bus, stalls the upstream pipeline while an access is outstanding, and registers the writeback bundle for the WB stage. It sits between the EX/MEM register and the MEM/WB boundary. While stalled, it emits bubbles toward WB.

## Interface
- TIMEOUT_CYCLES, 255: maximum wait cycles per access before abort (1..65535; counter width is $clog2(TIMEOUT_CYCLES+1)).
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_shouldWriteRegister  in  1  instruction writes the register file.
- mem_registerWriteAddress  in  5  destination register.
- mem_shouldWriteMemoryElseAluOutputToRegister  in  1  load: writeback data comes from memory, else from the ALU.
- mem_aluOutput  in  32  effective address, or ALU result.
- mem_shouldWriteMemory  in  1  store.
- mem_registerRtOrZero  in  32  store data.
- stall  out  1  hold EX/MEM and earlier stages this cycle; combinational.
- dmem_request  out  1  access request; combinational.
- dmem_write  out  1  1 = store, 0 = load.
- dmem_address  out  32  word address (mem_aluOutput).
- dmem_writeData  out  32  store data.
- dmem_grant  in  1  memory accepts the request this cycle.
- dmem_readValid  in  1  load data valid this cycle.
- dmem_readData  in  32  load data.
- wb_shouldWriteRegister  out  1  registered.
- wb_registerWriteAddress  out  5  registered.
- wb_registerWriteData  out  32  registered.
- wb_addressError  out  1  registered one-cycle pulse: misaligned access.
- wb_busError  out  1  registered one-cycle pulse: access timed out.

## Operation
- Load = mem_shouldWriteMemoryElseAluOutputToRegister. Store = mem_shouldWriteMemory. MemOp = load or store. Both set together means store with load writeback; this is illegal upstream and is not checked.
- Misaligned = MemOp and mem_aluOutput[1:0] != 0. In this case there is no request and no stall. Next edge: wb_addressError=1, wb_shouldWriteRegister=0, other wb_* fields latched as usual.
- FSM states: IDLE, REQUEST, WAIT_READ.
  - IDLE with no MemOp: stall=0. WB latches {mem_shouldWriteRegister, mem_registerWriteAddress, mem_aluOutput}.
  - IDLE or REQUEST with an aligned MemOp: dmem_request=1, with dmem_write/address/writeData driven from the inputs.
    - Store with grant: stall=0, the WB bundle latches, next state IDLE.
    - Load with grant: stall=1, next state WAIT_READ.
    - No grant: stall=1, next state REQUEST.
  - WAIT_READ: dmem_request=0.
    - dmem_readValid: stall=0, WB latches wb_registerWriteData=dmem_readData, next state IDLE.
    - Otherwise: stall=1.
- Every cycle with stall=1, WB latches a bubble: wb_shouldWriteRegister=0, address 0, data 0.
- Upstream holds all mem_* inputs stable while stall=1.
- Timeout counter:
  - Clears whenever the next state is IDLE.
  - Increments on each cycle spent in REQUEST or WAIT_READ.
  - When it reaches TIMEOUT_CYCLES with no completing event that cycle: stall=0, dmem_request=0, wb_busError=1 and wb_shouldWriteRegister=0 next edge, next state IDLE.
- dmem_readValid in IDLE or REQUEST is ignored. dmem_grant in WAIT_READ is ignored.

## Timing
- Reset asserted (reset=0) clears state to IDLE, the counter to 0, and all wb_* outputs to 0 immediately. While reset is asserted, dmem_request=0 and stall=0.
- Reset mid-access abandons the access. Any later readValid for it is ignored.
- Latencies:
  - Non-memory instruction or granted store: 1 cycle to wb_*.
  - Load: grant cycle + N wait cycles + 1 edge. The minimum is a 2-cycle stall-free gap, i.e. 1 stall cycle.
- Same cycle as the timeout: grant (store) or readValid (load) wins, and no busError is raised.
- wb_addressError and wb_busError are never both 1.

## Test plan
- Reset then ALU op (aluOutput=0x1234, writeReg=1, addr=5, no MemOp) -> next cycle wb_*={1,5,0x1234}, stall never 1.
- Store addr 0x100, data 0xDEADBEEF, grant same cycle -> dmem_request=1, dmem_write=1, stall=0, no WB write.
- Load addr 0x200, grant after 2 cycles, readValid 3 cycles later with 0xCAFEF00D -> stall high 5 cycles, bubbles on WB, then wb_registerWriteData=0xCAFEF00D with write enabled.
- Load addr 0x203 -> no request, no stall, wb_addressError pulse, wb_shouldWriteRegister=0.
- TIMEOUT_CYCLES=4, load granted, readValid never asserted -> stall released after 4 wait cycles, wb_busError pulse, FSM IDLE; a late readValid is ignored.
- Reset deasserted→asserted while in WAIT_READ -> all outputs 0 asynchronously; after release an ALU op passes through normally.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage and the memory.
// The master issues requests; the slave answers with grant, then read data.
interface mem_access_stage_if;
    logic        dmem_request;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_writeData;
    logic        dmem_grant;
    logic        dmem_readValid;
    logic [31:0] dmem_readData;

    modport master (
        output dmem_request, dmem_write, dmem_address, dmem_writeData,
        input  dmem_grant, dmem_readValid, dmem_readData
    );

    modport slave (
        input  dmem_request, dmem_write, dmem_address, dmem_writeData,
        output dmem_grant, dmem_readValid, dmem_readData
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: performs loads and stores over a variable-latency memory bus,
// stalls upstream while an access is outstanding and registers the writeback bundle.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        mem_shouldWriteRegister,
    input  logic [4:0]                  mem_registerWriteAddress,
    input  logic                        mem_shouldWriteMemoryElseAluOutputToRegister,
    input  logic [31:0]                 mem_aluOutput,
    input  logic                        mem_shouldWriteMemory,
    input  logic [31:0]                 mem_registerRtOrZero,
    output logic                        stall,
    mem_access_stage_if.master          dmem,
    output logic                        wb_shouldWriteRegister,
    output logic [4:0]                  wb_registerWriteAddress,
    output logic [31:0]                 wb_registerWriteData,
    output logic                        wb_addressError,
    output logic                        wb_busError
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQUEST, WAIT_READ} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;

    logic            r_wb_we;
    logic [4:0]      r_wb_addr;
    logic [31:0]     r_wb_data;
    logic            r_wb_aerr;
    logic            r_wb_berr;

    logic            w_wb_we;
    logic [4:0]      w_wb_addr;
    logic [31:0]     w_wb_data;
    logic            w_wb_aerr;
    logic            w_wb_berr;

    logic            w_load;
    logic            w_store;
    logic            w_memop;
    logic            w_misaligned;
    logic            w_at_limit;
    logic            w_req_raw;
    logic            w_stall_raw;

    assign w_load       = mem_shouldWriteMemoryElseAluOutputToRegister;
    assign w_store      = mem_shouldWriteMemory;
    assign w_memop      = w_load | w_store;
    assign w_misaligned = w_memop & (mem_aluOutput[1:0] != 2'b00);
    assign w_at_limit   = (r_state != IDLE) && (r_count == CW'(TIMEOUT_CYCLES));

    always_comb begin
        w_state_next = r_state;
        w_req_raw    = 1'b0;
        w_stall_raw  = 1'b0;
        // Default bundle is a bubble; every stalled cycle keeps it.
        w_wb_we      = 1'b0;
        w_wb_addr    = 5'd0;
        w_wb_data    = 32'd0;
        w_wb_aerr    = 1'b0;
        w_wb_berr    = 1'b0;
        case (r_state)
            IDLE, REQUEST: begin
                if (!w_memop) begin
                    w_wb_we      = mem_shouldWriteRegister;
                    w_wb_addr    = mem_registerWriteAddress;
                    w_wb_data    = mem_aluOutput;
                    w_state_next = IDLE;
                end else if (w_misaligned) begin
                    w_wb_addr    = mem_registerWriteAddress;
                    w_wb_data    = mem_aluOutput;
                    w_wb_aerr    = 1'b1;
                    w_state_next = IDLE;
                end else if (w_store && dmem.dmem_grant) begin
                    // A granted store completes even on the timeout cycle.
                    w_req_raw    = 1'b1;
                    w_wb_we      = mem_shouldWriteRegister;
                    w_wb_addr    = mem_registerWriteAddress;
                    w_wb_data    = mem_aluOutput;
                    w_state_next = IDLE;
                end else if (w_at_limit) begin
                    w_wb_berr    = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_req_raw    = 1'b1;
                    w_stall_raw  = 1'b1;
                    w_state_next = dmem.dmem_grant ? WAIT_READ : REQUEST;
                end
            end
            WAIT_READ: begin
                if (dmem.dmem_readValid) begin
                    w_wb_we      = mem_shouldWriteRegister;
                    w_wb_addr    = mem_registerWriteAddress;
                    w_wb_data    = dmem.dmem_readData;
                    w_state_next = IDLE;
                end else if (w_at_limit) begin
                    w_wb_berr    = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_stall_raw  = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        if (w_state_next == IDLE) begin
            w_count_next = '0;
        end else if (r_state != IDLE) begin
            w_count_next = r_count + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_wb_we   <= 1'b0;
            r_wb_addr <= 5'd0;
            r_wb_data <= 32'd0;
            r_wb_aerr <= 1'b0;
            r_wb_berr <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_wb_we   <= w_wb_we;
            r_wb_addr <= w_wb_addr;
            r_wb_data <= w_wb_data;
            r_wb_aerr <= w_wb_aerr;
            r_wb_berr <= w_wb_berr;
        end
    end

    // Combinational handshake outputs are forced quiet while reset is held.
    assign stall               = w_stall_raw & reset;
    assign dmem.dmem_request   = w_req_raw & reset;
    assign dmem.dmem_write     = w_store;
    assign dmem.dmem_address   = mem_aluOutput;
    assign dmem.dmem_writeData = mem_registerRtOrZero;

    assign wb_shouldWriteRegister  = r_wb_we;
    assign wb_registerWriteAddress = r_wb_addr;
    assign wb_registerWriteData    = r_wb_data;
    assign wb_addressError         = r_wb_aerr;
    assign wb_busError             = r_wb_berr;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a four-cycle access timeout.
module tb_mem_access_stage;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_we = 1'b0;
    logic [4:0]  mem_waddr = 5'd0;
    logic        mem_load = 1'b0;
    logic [31:0] mem_alu = 32'd0;
    logic        mem_store = 1'b0;
    logic [31:0] mem_rt = 32'd0;
    logic        stall;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_aerr;
    logic        wb_berr;

    int n_checks = 0;
    int n_fail   = 0;
    int stalls;

    mem_access_stage_if dmem_bus ();

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clock                                        (clock),
        .reset                                        (reset),
        .mem_shouldWriteRegister                      (mem_we),
        .mem_registerWriteAddress                     (mem_waddr),
        .mem_shouldWriteMemoryElseAluOutputToRegister (mem_load),
        .mem_aluOutput                                (mem_alu),
        .mem_shouldWriteMemory                        (mem_store),
        .mem_registerRtOrZero                         (mem_rt),
        .stall                                        (stall),
        .dmem                                         (dmem_bus),
        .wb_shouldWriteRegister                       (wb_we),
        .wb_registerWriteAddress                      (wb_waddr),
        .wb_registerWriteData                         (wb_wdata),
        .wb_addressError                              (wb_aerr),
        .wb_busError                                  (wb_berr)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, act);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic ld,
                         input logic st, input logic [31:0] alu, input logic [31:0] rt);
        mem_we = we; mem_waddr = wa; mem_load = ld; mem_store = st; mem_alu = alu; mem_rt = rt;
    endtask

    initial begin
        dmem_bus.dmem_grant     = 1'b0;
        dmem_bus.dmem_readValid = 1'b0;
        dmem_bus.dmem_readData  = 32'd0;

        // Reset held with an aligned load presented: outputs must stay quiet.
        drive(1'b1, 5'd1, 1'b1, 1'b0, 32'h10, 32'd0);
        #1;
        check_val("rst_stall", {31'd0, stall}, 32'd0);
        check_val("rst_req", {31'd0, dmem_bus.dmem_request}, 32'd0);
        cycle();
        check_val("rst_wb_we", {31'd0, wb_we}, 32'd0);
        check_val("rst_wb_data", wb_wdata, 32'd0);
        reset = 1'b1;

        // ALU op passes through in one cycle.
        drive(1'b1, 5'd5, 1'b0, 1'b0, 32'h1234, 32'd0);
        #1;
        check_val("alu_stall", {31'd0, stall}, 32'd0);
        check_val("alu_req", {31'd0, dmem_bus.dmem_request}, 32'd0);
        cycle();
        check_val("alu_wb_we", {31'd0, wb_we}, 32'd1);
        check_val("alu_wb_addr", {27'd0, wb_waddr}, 32'd5);
        check_val("alu_wb_data", wb_wdata, 32'h1234);

        // Store granted in the same cycle.
        drive(1'b0, 5'd0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF);
        dmem_bus.dmem_grant = 1'b1;
        #1;
        check_val("st_req", {31'd0, dmem_bus.dmem_request}, 32'd1);
        check_val("st_write", {31'd0, dmem_bus.dmem_write}, 32'd1);
        check_val("st_addr", dmem_bus.dmem_address, 32'h100);
        check_val("st_wdata", dmem_bus.dmem_writeData, 32'hDEADBEEF);
        check_val("st_stall", {31'd0, stall}, 32'd0);
        cycle();
        check_val("st_wb_we", {31'd0, wb_we}, 32'd0);

        // Load: grant on the third cycle, readValid three cycles later (on the limit cycle).
        drive(1'b1, 5'd7, 1'b1, 1'b0, 32'h200, 32'd0);
        stalls = 0;
        for (int i = 0; i < 6; i++) begin
            dmem_bus.dmem_grant     = (i == 2);
            dmem_bus.dmem_readValid = (i == 5);
            dmem_bus.dmem_readData  = (i == 5) ? 32'hCAFEF00D : 32'h0BADBAD0;
            #1;
            check_val($sformatf("ld_req_%0d", i), {31'd0, dmem_bus.dmem_request}, {31'd0, (i <= 2)});
            if (stall) stalls++;
            cycle();
            if (i < 5) begin
                check_val($sformatf("ld_bubble_%0d", i), {31'd0, wb_we}, 32'd0);
            end
        end
        dmem_bus.dmem_grant     = 1'b0;
        dmem_bus.dmem_readValid = 1'b0;
        check_val("ld_stall_cycles", stalls, 32'd5);
        check_val("ld_wb_we", {31'd0, wb_we}, 32'd1);
        check_val("ld_wb_addr", {27'd0, wb_waddr}, 32'd7);
        check_val("ld_wb_data", wb_wdata, 32'hCAFEF00D);
        check_val("ld_wb_berr", {31'd0, wb_berr}, 32'd0);

        // Misaligned load.
        drive(1'b1, 5'd9, 1'b1, 1'b0, 32'h203, 32'd0);
        #1;
        check_val("mis_req", {31'd0, dmem_bus.dmem_request}, 32'd0);
        check_val("mis_stall", {31'd0, stall}, 32'd0);
        cycle();
        check_val("mis_aerr", {31'd0, wb_aerr}, 32'd1);
        check_val("mis_wb_we", {31'd0, wb_we}, 32'd0);
        check_val("mis_berr", {31'd0, wb_berr}, 32'd0);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle();
        check_val("mis_aerr_pulse", {31'd0, wb_aerr}, 32'd0);

        // Load granted immediately, readValid never comes: timeout after four wait cycles.
        drive(1'b1, 5'd3, 1'b1, 1'b0, 32'h300, 32'd0);
        stalls = 0;
        for (int i = 0; i < 6; i++) begin
            dmem_bus.dmem_grant = (i == 0);
            #1;
            check_val($sformatf("to_stall_%0d", i), {31'd0, stall}, {31'd0, (i < 5)});
            if (stall) stalls++;
            cycle();
        end
        dmem_bus.dmem_grant = 1'b0;
        check_val("to_stall_cycles", stalls, 32'd5);
        check_val("to_berr", {31'd0, wb_berr}, 32'd1);
        check_val("to_aerr", {31'd0, wb_aerr}, 32'd0);
        check_val("to_wb_we", {31'd0, wb_we}, 32'd0);

        // Late readValid in IDLE is ignored; ALU op goes through.
        drive(1'b1, 5'd4, 1'b0, 1'b0, 32'h55, 32'd0);
        dmem_bus.dmem_readValid = 1'b1;
        dmem_bus.dmem_readData  = 32'h00000BAD;
        #1;
        check_val("late_stall", {31'd0, stall}, 32'd0);
        cycle();
        dmem_bus.dmem_readValid = 1'b0;
        check_val("late_wb_data", wb_wdata, 32'h55);
        check_val("late_wb_we", {31'd0, wb_we}, 32'd1);
        check_val("late_berr", {31'd0, wb_berr}, 32'd0);

        // Reset in WAIT_READ abandons the access asynchronously.
        drive(1'b1, 5'd8, 1'b1, 1'b0, 32'h400, 32'd0);
        dmem_bus.dmem_grant = 1'b1;
        cycle();
        dmem_bus.dmem_grant = 1'b0;
        check_val("ar_wait_stall", {31'd0, stall}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_val("ar_stall", {31'd0, stall}, 32'd0);
        check_val("ar_req", {31'd0, dmem_bus.dmem_request}, 32'd0);
        check_val("ar_wb_we", {31'd0, wb_we}, 32'd0);
        cycle();
        reset = 1'b1;
        drive(1'b1, 5'd6, 1'b0, 1'b0, 32'hABC, 32'd0);
        dmem_bus.dmem_readValid = 1'b1;
        dmem_bus.dmem_readData  = 32'h0000DEAD;
        #1;
        check_val("post_stall", {31'd0, stall}, 32'd0);
        cycle();
        dmem_bus.dmem_readValid = 1'b0;
        check_val("post_wb_we", {31'd0, wb_we}, 32'd1);
        check_val("post_wb_addr", {27'd0, wb_waddr}, 32'd6);
        check_val("post_wb_data", wb_wdata, 32'hABC);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
